// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-port memory initiator.
package data_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int MEM_SIZE_DEF = 256;
  localparam int AW_DEF       = $clog2(MEM_SIZE_DEF);
  localparam int IDX_LSB      = 2;
  localparam int WAIT_MIN     = 1;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter holding a memory enable for a fixed number of cycles.
module mem_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/data_mem_initiator.sv
// Data-port requester: SETUP/ACCESS/RESP sequencing of the unified memory.
// Optional misaligned-address error path: DATA_MEM_ALIGN_CHECK_EN.
module data_mem_initiator
  import data_mem_pkg::*;
#(
  parameter  int MEM_WIDTH   = 32,
  parameter  int MEM_SIZE    = 256,
  parameter  int WAIT_CYCLES = 1,
  localparam int AW          = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [MEM_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [MEM_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 busy,
  output logic [AW-1:0]        mem_addr_data,
  output logic                 mem_read_en_data,
  output logic                 mem_write_en_data,
  output logic [MEM_WIDTH-1:0] mem_write_val_data,
  input  logic [MEM_WIDTH-1:0] mem_read_val_data
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  if (WAIT_CYCLES < WAIT_MIN) begin : g_wait_chk
    $error("WAIT_CYCLES must be at least 1");
  end

  state_t               r_state;
  logic                 r_write;
  logic [AW-1:0]        r_addr;
  logic [MEM_WIDTH-1:0] r_wval;
  logic                 r_re;
  logic                 r_we;
  logic                 r_rv;
  logic [MEM_WIDTH-1:0] r_rdata;
  logic                 w_cnt_zero;
  logic                 w_unused_addr;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic                 r_err;
`endif

  assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  mem_wait_counter #(
    .W (CW)
  ) u_wait (
    .clk     (clk),
    .rst     (reset),
    .i_load  (r_state == ST_SETUP),
    .i_value (CW'(WAIT_CYCLES - 1)),
    .i_en    (r_state == ST_ACCESS),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wval  <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_rv    <= 1'b0;
      r_rdata <= '0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
`ifdef DATA_MEM_ALIGN_CHECK_EN
            if (|req_addr[1:0]) begin
              r_state <= ST_RESP;
              r_rv    <= 1'b1;
              r_err   <= 1'b1;
            end else
`endif
            begin
              r_state <= ST_SETUP;
              r_addr  <= req_addr[AW+1:IDX_LSB];
              r_write <= req_write;
              r_wval  <= req_write ? req_wdata : '0;
            end
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_re    <= ~r_write;
          r_we    <= r_write;
        end
        ST_ACCESS: begin
          if (w_cnt_zero) begin
            r_state <= ST_RESP;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_rv    <= 1'b1;
            if (!r_write) r_rdata <= mem_read_val_data;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_rv    <= 1'b0;
          r_rdata <= '0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
          r_err   <= 1'b0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready          = (r_state == ST_IDLE) && !reset;
  assign busy               = (r_state != ST_IDLE);
  assign resp_valid         = r_rv;
  assign resp_rdata         = r_rdata;
  assign mem_addr_data      = r_addr;
  assign mem_read_en_data   = r_re;
  assign mem_write_en_data  = r_we;
  assign mem_write_val_data = r_wval;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign resp_err           = r_err;
`else
  assign resp_err           = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench: two initiators (WAIT_CYCLES 1 and 3) on behavioural memories.
module tb_data_mem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;

  logic        v1, w1, v3, w3;
  logic [31:0] a1, d1, a3, d3;
  logic        rdy1, rv1, er1, bz1, re1, we1;
  logic        rdy3, rv3, er3, bz3, re3, we3;
  logic [31:0] rd1, wv1, mrv1, rd3, wv3, mrv3;
  logic [7:0]  ma1, ma3;

  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  always #5 clk = ~clk;

  data_mem_initiator #(
    .MEM_WIDTH(32), .MEM_SIZE(256), .WAIT_CYCLES(1)
  ) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_addr(a1), .req_wdata(d1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1),
    .busy(bz1), .mem_addr_data(ma1),
    .mem_read_en_data(re1), .mem_write_en_data(we1),
    .mem_write_val_data(wv1), .mem_read_val_data(mrv1)
  );

  data_mem_initiator #(
    .MEM_WIDTH(32), .MEM_SIZE(256), .WAIT_CYCLES(3)
  ) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(v3), .req_ready(rdy3), .req_write(w3),
    .req_addr(a3), .req_wdata(d3),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3),
    .busy(bz3), .mem_addr_data(ma3),
    .mem_read_en_data(re3), .mem_write_en_data(we3),
    .mem_write_val_data(wv3), .mem_read_val_data(mrv3)
  );

  assign mrv1 = mem1[ma1];
  assign mrv3 = mem3[ma3];

  always @(posedge clk) begin
    if (pre_we) begin
      mem1[pre_a] <= pre_d;
      mem3[pre_a] <= pre_d;
    end else begin
      if (we1) mem1[ma1] <= wv1;
      if (we3) mem3[ma3] <= wv3;
    end
  end

  // One request on the selected instance; c counts edges after acceptance.
  task automatic run(
    input  int          sel,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output int          lat,
    output int          en_cyc,
    output int          first_en,
    output int          rdy_hi,
    output logic        ovl,
    output logic [7:0]  en_addr,
    output logic [7:0]  su_addr,
    output logic [31:0] su_wv,
    output logic [31:0] rd,
    output logic        er
  );
    logic s_rv, s_re, s_we, s_rdy;
    if (sel == 3) begin
      v3 = 1'b1; w3 = wr; a3 = addr; d3 = wd;
    end else begin
      v1 = 1'b1; w1 = wr; a1 = addr; d1 = wd;
    end
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    lat = -1; en_cyc = 0; first_en = -1; rdy_hi = 0; ovl = 1'b0;
    en_addr = '0; su_addr = '0; su_wv = '0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      s_rv  = (sel == 3) ? rv3  : rv1;
      s_re  = (sel == 3) ? re3  : re1;
      s_we  = (sel == 3) ? we3  : we1;
      s_rdy = (sel == 3) ? rdy3 : rdy1;
      if (c == 1) begin
        su_addr = (sel == 3) ? ma3 : ma1;
        su_wv   = (sel == 3) ? wv3 : wv1;
      end
      if (s_re | s_we) begin
        en_cyc++;
        if (first_en < 0) first_en = c;
        en_addr = (sel == 3) ? ma3 : ma1;
      end
      if (s_re & s_we) ovl = 1'b1;
      if (s_rdy) rdy_hi++;
      if (s_rv) begin
        lat = c;
        rd  = (sel == 3) ? rd3 : rd1;
        er  = (sel == 3) ? er3 : er1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({rdy1, rv1, er1, bz1, re1, we1} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {rdy1, rv1, er1, bz1, re1, we1});
    end
    checks++;
    if ({rd1, wv1, ma1} !== 72'd0) begin
      errors++;
      $display("FAIL reset_data: got rd=%h wv=%h ma=%h want 0", rd1, wv1, ma1);
    end
  endtask

  task automatic test_load();
    int lat, en, fe, rh; logic ov, er; logic [7:0] ea, sa; logic [31:0] sw, rd;
    run(1, 1'b0, 32'h10, 32'h0, lat, en, fe, rh, ov, ea, sa, sw, rd, er);
    checks++;
    if (fe !== 2 || en !== 1) begin
      errors++;
      $display("FAIL load_enable: first=%0d cycles=%0d want 2/1", fe, en);
    end
    checks++;
    if (ea !== 8'd4 || sa !== 8'd4) begin
      errors++;
      $display("FAIL load_addr: en=%0d setup=%0d want 4", ea, sa);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL load_latency: got %0d want 3", lat);
    end
    checks++;
    if (rd !== 32'h1 || er !== 1'b0) begin
      errors++;
      $display("FAIL load_data: got %h err=%b want 00000001 err=0", rd, er);
    end
    checks++;
    if (rv1 !== 1'b0 || rd1 !== 32'h0 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL load_resp_clear: rv=%b rd=%h rdy=%b want 0/0/1", rv1, rd1, rdy1);
    end
  endtask

  task automatic test_store_load();
    int lat, en, fe, rh; logic ov, er; logic [7:0] ea, sa; logic [31:0] sw, rd;
    run(1, 1'b1, 32'h40, 32'hDEADBEEF, lat, en, fe, rh, ov, ea, sa, sw, rd, er);
    checks++;
    if (en !== 1 || fe !== 2 || ea !== 8'd16) begin
      errors++;
      $display("FAIL store_enable: cycles=%0d first=%0d addr=%0d want 1/2/16", en, fe, ea);
    end
    checks++;
    if (sa !== 8'd16 || sw !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_setup: addr=%0d data=%h want 16 deadbeef", sa, sw);
    end
    checks++;
    if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: lat=%0d rd=%h err=%b want 3/0/0", lat, rd, er);
    end
    run(1, 1'b0, 32'h40, 32'h0, lat, en, fe, rh, ov, ea, sa, sw, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_readback: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_wrap();
    int lat, en, fe, rh; logic ov, er; logic [7:0] ea, sa; logic [31:0] sw, rd;
    run(1, 1'b0, 32'h0000_0410, 32'h0, lat, en, fe, rh, ov, ea, sa, sw, rd, er);
    checks++;
    if (ea !== 8'd4 || rd !== 32'h1) begin
      errors++;
      $display("FAIL addr_wrap: addr=%0d rd=%h want 4 00000001", ea, rd);
    end
  endtask

  task automatic test_wait3();
    int lat, en, fe, rh; logic ov, er; logic [7:0] ea, sa; logic [31:0] sw, rd;
    run(3, 1'b0, 32'h10, 32'h0, lat, en, fe, rh, ov, ea, sa, sw, rd, er);
    checks++;
    if (en !== 3 || fe !== 2) begin
      errors++;
      $display("FAIL wait3_enable: cycles=%0d first=%0d want 3/2", en, fe);
    end
    checks++;
    if (lat !== 5 || rd !== 32'h1) begin
      errors++;
      $display("FAIL wait3_resp: lat=%0d rd=%h want 5 00000001", lat, rd);
    end
    checks++;
    if (rh !== 0) begin
      errors++;
      $display("FAIL wait3_ready: high %0d cycles while busy want 0", rh);
    end
  endtask

  task automatic test_back_to_back();
    int n; int t [2]; logic [31:0] r [2]; logic ov;
    n = 0; ov = 1'b0; t[0] = 0; t[1] = 0; r[0] = '0; r[1] = '0;
    v1 = 1'b1; w1 = 1'b0; a1 = 32'h40; d1 = 32'h0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (re1 & we1) ov = 1'b1;
      if (rv1 && n < 2) begin
        t[n] = c; r[n] = rd1; n++;
        if (n == 2) v1 = 1'b0;
      end
    end
    checks++;
    if (n !== 2 || (t[1] - t[0]) !== 4) begin
      errors++;
      $display("FAIL b2b_spacing: n=%0d gap=%0d want 2/4", n, t[1] - t[0]);
    end
    checks++;
    if (r[0] !== 32'hDEADBEEF || r[1] !== 32'hDEADBEEF || ov !== 1'b0) begin
      errors++;
      $display("FAIL b2b_data: %h %h ovl=%b want deadbeef x2 ovl=0", r[0], r[1], ov);
    end
  endtask

  task automatic test_align();
    int lat, en, fe, rh; logic ov, er; logic [7:0] ea, sa; logic [31:0] sw, rd;
    run(1, 1'b0, 32'h13, 32'h0, lat, en, fe, rh, ov, ea, sa, sw, rd, er);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    checks++;
    if (en !== 0 || lat !== 1) begin
      errors++;
      $display("FAIL align_path: en=%0d lat=%0d want 0/1", en, lat);
    end
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL align_resp: err=%b rd=%h want 1 0", er, rd);
    end
`else
    checks++;
    if (en !== 1 || ea !== 8'd4 || lat !== 3) begin
      errors++;
      $display("FAIL align_path: en=%0d addr=%0d lat=%0d want 1/4/3", en, ea, lat);
    end
    checks++;
    if (er !== 1'b0 || rd !== 32'h1) begin
      errors++;
      $display("FAIL align_resp: err=%b rd=%h want 0 00000001", er, rd);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic seen;
    v1 = 1'b1; w1 = 1'b1; a1 = 32'h80; d1 = 32'h12345678;
    @(posedge clk); #1;
    v1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (we1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: we=%b want 1", we1);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (we1 !== 1'b0 || bz1 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: we=%b busy=%b rdy=%b want 0/0/0", we1, bz1, rdy1);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", rdy1);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rv1 | we1 | re1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_noresp: activity=%b want 0", seen);
    end
  endtask

  initial begin
    reset = 1'b1;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    v3 = 1'b0; w3 = 1'b0; a3 = '0; d3 = '0;
    pre_we = 1'b1; pre_a = 8'd4; pre_d = 32'h1;
    #1;
    checks++;
    if (rdy1 !== 1'b0 || bz1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b busy=%b want 0/0", rdy1, bz1);
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    test_reset();
    test_load();
    test_store_load();
    test_wrap();
    test_wait3();
    test_back_to_back();
    test_align();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_initiator.md
Name: data_mem_initiator

Overview:
- Requester-side controller for the data port of the unified instruction/data memory.
- Accepts single load/store requests from the CPU datapath over a valid/ready handshake.
- Sequences the memory's level-sensitive data port with address-before-enable discipline and a configurable access wait.
- Returns a registered one-cycle response with read data.
- Sits between the MEM pipeline stage and the memory's mem_*_data ports.

Parameters:
- MEM_WIDTH, 32: data word width, matching the memory.
- MEM_SIZE, 256: memory depth in words. AW = $clog2(MEM_SIZE).
- WAIT_CYCLES, 1: number of cycles the read/write enable is held asserted. Legal range >= 1; 0 fails elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address. The word index is req_addr[AW+1:2].
- req_wdata  in  MEM_WIDTH  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  MEM_WIDTH  load data. 0 for stores and errors.
- resp_err  out  1  error flag, qualified by resp_valid.
- busy  out  1  high whenever state != IDLE.
- mem_addr_data  out  AW  word address to memory.
- mem_read_en_data  out  1  memory read enable.
- mem_write_en_data  out  1  memory write enable.
- mem_write_val_data  out  MEM_WIDTH  memory write data.
- mem_read_val_data  in  MEM_WIDTH  memory read data.

Behaviour:
- Reset is asynchronous, active-high, single clock domain.
- Reset values: state IDLE, all memory outputs 0, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, wait counter 0.
- req_ready = (state == IDLE) && !reset.
- FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - On req_valid && req_ready, latch word index, req_write and req_wdata; go to SETUP.
  - req_valid without acceptance has no effect.
- SETUP (1 cycle):
  - Drive mem_addr_data. For stores, also drive mem_write_val_data.
  - Both enables stay 0, so the address/data are stable before any enable rises.
- ACCESS (WAIT_CYCLES cycles):
  - Assert mem_read_en_data (load) or mem_write_en_data (store). Address and write data are held.
  - The counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - When the counter reaches 0: for loads, register mem_read_val_data into resp_rdata; go to RESP.
- RESP (1 cycle):
  - Enables drop to 0; address and data are held.
  - resp_valid = 1. There is no backpressure: the CPU must sample it that cycle.
  - Next state is IDLE. resp_valid, resp_rdata and resp_err are cleared on leaving RESP.
- Latency: request accepted at edge k -> resp_valid high during cycle k+2+WAIT_CYCLES. Throughput is one request per 3+WAIT_CYCLES cycles.
- Exactly one enable is ever high. Both enables are low outside ACCESS.
- req_addr bits above AW+1 are ignored (wrap modulo MEM_SIZE words).
- Reset mid-ACCESS: enables drop immediately (asynchronously). An in-flight store may or may not have landed. No response is issued.
- A new req_valid during SETUP/ACCESS/RESP is not accepted (req_ready = 0). The requester holds it until IDLE.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- When defined:
  - Accepting a request with req_addr[1:0] != 0 goes IDLE -> RESP directly, with no memory access.
  - That response has resp_err = 1 and resp_rdata = 0. Latency is 1 cycle.
- When undefined:
  - req_addr[1:0] is ignored and resp_err is tied to 0.

Decomposition:
- Shared package data_mem_pkg:
  - State encoding typedef (IDLE, SETUP, ACCESS, RESP).
  - Localparams for AW and the word-index slice position (2).
  - WAIT_CYCLES minimum check constant.
- One natural sub-module, mem_wait_counter:
  - Loadable down-counter, width $clog2(WAIT_CYCLES+1).
  - Ports: load, value, en, zero flag.
  - Reusable by the instruction-fetch side.

Test Plan:
- Load, WAIT_CYCLES=1, memory word 4 preloaded 0x00000001; req_addr=0x10, req_write=0 -> enable stays low in the SETUP cycle; mem_read_en_data high exactly 1 cycle at address 4; resp_valid at k+3 with resp_rdata=0x00000001, resp_err=0.
- Store then load, req_addr=0x40, req_wdata=0xDEADBEEF -> mem_write_en_data high 1 cycle with address 16 and data stable from SETUP; following load of 0x40 returns 0xDEADBEEF.
- WAIT_CYCLES=3 load -> enable high exactly 3 cycles; resp_valid at k+5; req_ready low from k+1 through k+5.
- Back-to-back: req_valid held high for two requests -> second accepted only when state returns to IDLE; responses 4 cycles apart (WAIT_CYCLES=1); enables never overlap.
- Reset asserted asynchronously mid-ACCESS of a store -> mem_write_en_data and busy fall before the next clk edge; no resp_valid; req_ready=1 after reset release.
- DATA_MEM_ALIGN_CHECK_EN defined, req_addr=0x13 -> no memory enable; resp_valid at k+1 with resp_err=1, resp_rdata=0. With the macro undefined, the same request accesses word 4 with resp_err=0.
